m_dmem_ctrl: RTL and testbench

//  M-stage data-memory access controller. Shares one data-memory/bridge bus port between the CPU M-stage and a DMA requester.

---
 rtl/m_dmem_pkg.sv | 20 ++
 rtl/m_dmem_arb.sv | 40 ++++
 rtl/m_dmem_ctrl.sv | 155 +++++++++++++++
 tb/tb_m_dmem_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/m_dmem_pkg.sv
// Shared types and defaults for the M-stage data-memory access controller.
package m_dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  localparam int unsigned DEF_TIMEOUT    = 255;
  localparam int unsigned DEF_STARVE_MAX = 4;
  localparam int unsigned TCNT_W         = 8;
  localparam logic [31:0] WORD_MASK      = 32'hFFFF_FFFC;

endpackage

// File: rtl/m_dmem_arb.sv
// CPU/DMA winner select with a DMA starvation counter that forces a DMA grant.
module m_dmem_arb
  import m_dmem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_arb_en,
  input  logic   i_cpu_valid,
  input  logic   i_dma_req,
  output logic   o_grant,
  output owner_t o_owner
);

  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [SW-1:0] r_starve;
  logic          w_starved;

  assign w_starved = (r_starve == SW'(STARVE_MAX));
  assign o_grant   = i_arb_en & (i_cpu_valid | i_dma_req);
  assign o_owner   = (i_dma_req & (~i_cpu_valid | w_starved)) ? OWN_DMA : OWN_CPU;

  // Losses only count in arbitration cycles; an idle DMA side resets the history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (!i_dma_req) begin
      r_starve <= '0;
    end else if (o_grant) begin
      if (o_owner == OWN_DMA) begin
        r_starve <= '0;
      end else if (!w_starved) begin
        r_starve <= r_starve + SW'(1);
      end
    end
  end

endmodule

// File: rtl/m_dmem_ctrl.sv
// M-stage data-memory controller: shares one bus port between CPU and DMA.
module m_dmem_ctrl
  import m_dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_be,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_exc,
  output logic        cpu_stall,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [3:0]  dma_be,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_done,
  output logic [31:0] dma_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        timeout_err
);

  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  owner_t              r_owner;
  owner_t              w_owner;
  logic [TCNT_W-1:0]   r_tcnt;
  logic                w_cpu_valid;
  logic                w_arb_en;
  logic                w_grant;
  logic                w_tout_hit;
  logic                w_busy_fin;
  logic                w_sel_we;
  logic [3:0]          w_sel_be;
  logic [31:0]         w_sel_addr;
  logic [31:0]         w_sel_wdata;
  logic [31:0]         w_resp_data;

  assign w_cpu_valid = cpu_req & ~cpu_exc;
  assign cpu_stall   = w_cpu_valid & ~cpu_done;
  assign w_arb_en    = (r_state == ST_IDLE);

  m_dmem_arb #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk         (clk),
    .rst_n       (reset),
    .i_arb_en    (w_arb_en),
    .i_cpu_valid (w_cpu_valid),
    .i_dma_req   (dma_req),
    .o_grant     (w_grant),
    .o_owner     (w_owner)
  );

  always_comb begin
    w_sel_we    = cpu_we;
    w_sel_be    = cpu_be;
    w_sel_addr  = cpu_addr;
    w_sel_wdata = cpu_wdata;
    if (w_owner == OWN_DMA) begin
      w_sel_we    = dma_we;
      w_sel_be    = dma_be;
      w_sel_addr  = dma_addr;
      w_sel_wdata = dma_wdata;
    end
  end

  // bus_req low in BUSY means a zero-byte-enable access: finish without a bus cycle.
  assign w_tout_hit  = bus_req & ~bus_ack & (r_tcnt == TCNT_LAST);
  assign w_busy_fin  = ~bus_req | bus_ack | w_tout_hit;
  assign w_resp_data = (bus_req & bus_ack) ? bus_rdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_grant)    w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_busy_fin) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner     <= OWN_CPU;
      r_tcnt      <= '0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_be      <= '0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      cpu_done    <= 1'b0;
      cpu_rdata   <= '0;
      dma_done    <= 1'b0;
      dma_rdata   <= '0;
      timeout_err <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      dma_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_owner   <= w_owner;
            r_tcnt    <= '0;
            bus_req   <= |w_sel_be;
            bus_we    <= w_sel_we;
            bus_be    <= w_sel_be;
            bus_addr  <= w_sel_addr & WORD_MASK;
            bus_wdata <= w_sel_wdata;
          end
        end
        ST_BUSY: begin
          if (w_busy_fin) begin
            bus_req <= 1'b0;
            if (w_tout_hit) timeout_err <= 1'b1;
            if (r_owner == OWN_DMA) begin
              dma_done  <= 1'b1;
              dma_rdata <= w_resp_data;
            end else begin
              cpu_done  <= 1'b1;
              cpu_rdata <= w_resp_data;
            end
          end else begin
            r_tcnt <= r_tcnt + TCNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_m_dmem_ctrl.sv
// Randomized bench for m_dmem_ctrl against a transaction-level timing model.
module tb_m_dmem_ctrl;

  localparam int TOUT = 8;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_exc;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_stall, cpu_done;
  logic [31:0] cpu_rdata;
  logic        dma_req, dma_we;
  logic [3:0]  dma_be;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_done;
  logic [31:0] dma_rdata;
  logic        bus_req, bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        timeout_err;

  always #5 clk = ~clk;

  m_dmem_ctrl #(.TIMEOUT(TOUT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_exc(cpu_exc), .cpu_stall(cpu_stall),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_be(dma_be), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_done(dma_done), .dma_rdata(dma_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .timeout_err(timeout_err)
  );

  int n_vec = 0;
  int n_err = 0;
  int t = 0;

  // Access model: one in-flight transaction described by its cycle numbers.
  bit          m_busy, m_dma, m_tout, m_terr;
  int          m_a, m_ack, m_req_last, m_done, m_starve;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_rd, m_cpu_rd, m_dma_rd;
  bit          cpu_granted, dma_granted;
  int          cpu_hold;
  int          p_cpu = 40, p_dma = 30, p_exc = 15, max_w = 10, force_w = -1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  function automatic bit chance(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  function automatic logic [3:0] rand_be();
    logic [3:0] be;
    be = 4'($urandom);
    if (chance(10)) be = 4'h0;
    return be;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_tout = 0; m_terr = 0; m_starve = 0;
    m_cpu_rd = '0; m_dma_rd = '0;
    cpu_granted = 0; dma_granted = 0;
    m_done = -1; m_a = -1; m_ack = -1; m_req_last = -1;
  endtask

  task automatic run_cycle();
    bit cv;
    int w;
    bit exp_req, exp_cd, exp_dd;
    if (m_busy && t > m_done) begin
      m_busy = 0;
      if (m_dma) begin dma_granted = 0; dma_req = 0; end
      else begin cpu_granted = 0; cpu_req = 0; cpu_exc = 0; end
    end
    if (cpu_req && !cpu_granted && cpu_exc) begin
      cpu_hold--;
      if (cpu_hold <= 0) begin cpu_req = 0; cpu_exc = 0; end
    end
    if (!cpu_req && chance(p_cpu)) begin
      cpu_req = 1; cpu_we = 1'($urandom); cpu_be = rand_be();
      cpu_addr = $urandom; cpu_wdata = $urandom;
      cpu_exc = chance(p_exc); cpu_hold = $urandom_range(1, 4);
    end
    if (cpu_granted && t < m_done && chance(8)) cpu_exc = 1;
    if (!dma_req && chance(p_dma)) begin
      dma_req = 1; dma_we = 1'($urandom); dma_be = rand_be();
      dma_addr = $urandom; dma_wdata = $urandom;
    end
    if (!m_busy) begin
      cv = cpu_req && !cpu_exc;
      if (cv || dma_req) begin
        m_dma = dma_req && (!cv || m_starve == SMAX);
        if (m_dma) begin
          m_we = dma_we; m_be = dma_be; m_addr = dma_addr; m_wdata = dma_wdata;
          dma_granted = 1; m_starve = 0;
        end else begin
          m_we = cpu_we; m_be = cpu_be; m_addr = cpu_addr; m_wdata = cpu_wdata;
          cpu_granted = 1;
          if (dma_req && m_starve < SMAX) m_starve++;
        end
        m_busy = 1; m_a = t; m_tout = 0; m_ack = -1;
        if (m_be == 4'h0) begin
          m_req_last = t; m_done = t + 2; m_rd = '0;
        end else begin
          w = (force_w >= 0) ? force_w : $urandom_range(0, max_w);
          if (w + 1 <= TOUT) begin
            m_ack = t + 1 + w; m_req_last = m_ack; m_done = m_ack + 1; m_rd = $urandom;
          end else begin
            m_req_last = t + TOUT; m_done = t + TOUT + 1; m_rd = '0; m_tout = 1;
          end
        end
      end
    end
    if (!dma_req) m_starve = 0;
    bus_ack   = m_busy && (t == m_ack);
    bus_rdata = bus_ack ? m_rd : $urandom;

    @(negedge clk);
    exp_req = m_busy && (m_be != 4'h0) && (t > m_a) && (t <= m_req_last);
    exp_cd  = m_busy && (t == m_done) && !m_dma;
    exp_dd  = m_busy && (t == m_done) && m_dma;
    if (exp_cd) m_cpu_rd = m_rd;
    if (exp_dd) m_dma_rd = m_rd;
    if ((exp_cd || exp_dd) && m_tout) m_terr = 1;
    check_val("bus_req", 32'(bus_req), 32'(exp_req));
    if (exp_req) begin
      check_val("bus_we",    32'(bus_we), 32'(m_we));
      check_val("bus_be",    32'(bus_be), 32'(m_be));
      check_val("bus_addr",  bus_addr,    m_addr & 32'hFFFF_FFFC);
      check_val("bus_wdata", bus_wdata,   m_wdata);
    end
    check_val("cpu_done",    32'(cpu_done),    32'(exp_cd));
    check_val("dma_done",    32'(dma_done),    32'(exp_dd));
    check_val("cpu_rdata",   cpu_rdata,        m_cpu_rd);
    check_val("dma_rdata",   dma_rdata,        m_dma_rd);
    check_val("timeout_err", 32'(timeout_err), 32'(m_terr));
    check_val("cpu_stall",   32'(cpu_stall),   32'(cpu_req && !cpu_exc && !exp_cd));
    @(posedge clk);
    #1;
    t++;
  endtask

  initial begin
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_be = '0; cpu_addr = '0; cpu_wdata = '0; cpu_exc = 0;
    dma_req = 0; dma_we = 0; dma_be = '0; dma_addr = '0; dma_wdata = '0;
    bus_ack = 0; bus_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_bus_req",   32'(bus_req),     32'd0);
    check_val("rst_bus_addr",  bus_addr,         32'd0);
    check_val("rst_bus_be",    32'(bus_be),      32'd0);
    check_val("rst_cpu_done",  32'(cpu_done),    32'd0);
    check_val("rst_dma_done",  32'(dma_done),    32'd0);
    check_val("rst_cpu_rdata", cpu_rdata,        32'd0);
    check_val("rst_terr",      32'(timeout_err), 32'd0);
    check_val("rst_stall",     32'(cpu_stall),   32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    repeat (3000) run_cycle();

    p_cpu = 100; p_dma = 100; p_exc = 0; force_w = 0;
    repeat (400) run_cycle();

    p_cpu = 0; p_dma = 0; force_w = -1;
    repeat (30) run_cycle();

    // Abort a CPU access in its second BUSY cycle with an asynchronous reset.
    cpu_req = 1; cpu_exc = 0; cpu_we = 0; cpu_be = 4'hF;
    cpu_addr = 32'h0000_0104; cpu_wdata = 32'h0; force_w = 50;
    run_cycle();
    run_cycle();
    check_val("pre_rst_bus_req", 32'(bus_req), 32'd1);
    reset = 1'b0;
    #1;
    check_val("async_bus_req",   32'(bus_req),     32'd0);
    check_val("async_cpu_done",  32'(cpu_done),    32'd0);
    check_val("async_cpu_rdata", cpu_rdata,        32'd0);
    check_val("async_terr",      32'(timeout_err), 32'd0);
    @(negedge clk);
    check_val("rst_hold_done",   32'(cpu_done),    32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    t++;
    model_reset();
    force_w = 2;
    repeat (20) run_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
